// File: rtl/spi_txn_arbiter.sv
// Round-robin scheduler that shares one SPI master among NREQ requesters,
// sequencing setup/transfer/capture and returning the received byte.
module spi_txn_arbiter #(
  parameter int NREQ         = 3,
  parameter int SETUP_CYCLES = 2,
  parameter int XFER_CYCLES  = 20,
  parameter int IDLE_GAP     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_slave,
  input  logic [2*NREQ-1:0] req_mode,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic [1:0]        spi_slaveno,
  output logic              spi_cpol,
  output logic              spi_cpha,
  output logic              spi_enable,
  output logic [7:0]        spi_data_out,
  input  logic [7:0]        spi_data_in
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_CAPTURE, S_RESP, S_GAP} state_t;

  state_t          state, nxt;
  logic [7:0]      cnt, cnt_d;
  logic [IW-1:0]   ptr, ptr_d, cur, cur_d, gidx;
  logic            err, err_d, ghit, grant;
  logic [1:0]      gslave, gmode;
  logic [7:0]      gdata;

  logic [NREQ-1:0] req_ready_d, rsp_valid_d;
  logic [7:0]      rsp_data_d, spi_data_out_d;
  logic            rsp_err_d, busy_d, spi_cpol_d, spi_cpha_d, spi_enable_d;
  logic [1:0]      spi_slaveno_d;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    ghit = 1'b0;
    gidx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!ghit && req_valid[(int'(ptr) + k) % NREQ]) begin
        ghit = 1'b1;
        gidx = IW'((int'(ptr) + k) % NREQ);
      end
    end
    gslave = req_slave[2*int'(gidx) +: 2];
    gmode  = req_mode[2*int'(gidx) +: 2];
    gdata  = req_data[8*int'(gidx) +: 8];
  end

  assign grant = (state == S_IDLE) && ghit && (cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ptr          <= '0;
      cur          <= '0;
      err          <= 1'b0;
      req_ready    <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      spi_slaveno  <= '0;
      spi_cpol     <= 1'b0;
      spi_cpha     <= 1'b0;
      spi_enable   <= 1'b0;
      spi_data_out <= '0;
    end else begin
      state        <= nxt;
      cnt          <= cnt_d;
      ptr          <= ptr_d;
      cur          <= cur_d;
      err          <= err_d;
      req_ready    <= req_ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_data     <= rsp_data_d;
      rsp_err      <= rsp_err_d;
      busy         <= busy_d;
      spi_slaveno  <= spi_slaveno_d;
      spi_cpol     <= spi_cpol_d;
      spi_cpha     <= spi_cpha_d;
      spi_enable   <= spi_enable_d;
      spi_data_out <= spi_data_out_d;
    end
  end

  always_comb begin
    nxt   = state;
    cnt_d = cnt;
    case (state)
      S_IDLE: if (grant) begin
        if (gslave == 2'd3) nxt = S_RESP;
        else begin
          nxt   = S_SETUP;
          cnt_d = 8'(SETUP_CYCLES - 1);
        end
      end
      S_SETUP: if (cnt == 8'd0) begin
        nxt   = S_XFER;
        cnt_d = 8'(XFER_CYCLES - 1);
      end else cnt_d = cnt - 8'd1;
      S_XFER: if (cnt == 8'd0) nxt = S_CAPTURE;
              else cnt_d = cnt - 8'd1;
      S_CAPTURE: nxt = S_RESP;
      S_RESP: if (IDLE_GAP == 0) nxt = S_IDLE;
              else begin
                nxt   = S_GAP;
                cnt_d = 8'(IDLE_GAP);
              end
      S_GAP: if (cnt <= 8'd1) begin
        nxt   = S_IDLE;
        cnt_d = 8'd0;
      end else cnt_d = cnt - 8'd1;
      default: nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; spi_* hold unless a valid grant reloads them.
  always_comb begin
    req_ready_d    = '0;
    rsp_valid_d    = '0;
    rsp_err_d      = 1'b0;
    rsp_data_d     = rsp_data;
    spi_slaveno_d  = spi_slaveno;
    spi_cpol_d     = spi_cpol;
    spi_cpha_d     = spi_cpha;
    spi_data_out_d = spi_data_out;
    ptr_d          = ptr;
    cur_d          = cur;
    err_d          = err;
    if (grant) begin
      req_ready_d[gidx] = 1'b1;
      ptr_d = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      cur_d = gidx;
      err_d = (gslave == 2'd3);
      if (gslave != 2'd3) begin
        spi_slaveno_d  = gslave;
        spi_cpol_d     = gmode[1];
        spi_cpha_d     = gmode[0];
        spi_data_out_d = gdata;
      end
    end
    if (state == S_CAPTURE) begin
      rsp_data_d       = spi_data_in;
      rsp_valid_d[cur] = 1'b1;
    end
    if (state == S_RESP && err) begin
      rsp_valid_d[cur] = 1'b1;
      rsp_err_d        = 1'b1;
      rsp_data_d       = 8'h00;
    end
    spi_enable_d = (nxt == S_XFER);
    busy_d       = (nxt != S_IDLE);
  end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter: stimulus pushes expected grants and
// responses, a negedge monitor pops and compares them as the DUT emits them.
module tb_spi_txn_arbiter;
  localparam int NREQ = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [5:0]      req_slave = '0, req_mode = '0;
  logic [23:0]     req_data = '0;
  logic [NREQ-1:0] req_ready, rsp_valid;
  logic [7:0]      rsp_data, spi_data_out, spi_data_in;
  logic            rsp_err, busy, spi_cpol, spi_cpha, spi_enable;
  logic [1:0]      spi_slaveno;

  spi_txn_arbiter #(.NREQ(NREQ), .SETUP_CYCLES(2), .XFER_CYCLES(20), .IDLE_GAP(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_slave(req_slave),
    .req_mode(req_mode), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .spi_slaveno(spi_slaveno), .spi_cpol(spi_cpol), .spi_cpha(spi_cpha),
    .spi_enable(spi_enable), .spi_data_out(spi_data_out), .spi_data_in(spi_data_in));

  always #5 clk = ~clk;

  // Slave model: echoes the transmitted byte XOR 0x99 (0xA5 -> 0x3C).
  assign spi_data_in = spi_data_out ^ 8'h99;

  typedef struct { int idx; int gap; } grant_t;
  typedef struct { int idx; logic [7:0] data; logic err; int lat; } rsp_t;

  grant_t exp_grant[$];
  rsp_t   exp_rsp[$];
  int checks = 0, errors = 0;
  int cyc = 0, last_ready = 0, en_rises = 0, run = 0;
  int ready_cyc[NREQ];
  logic prev_en = 1'b0, stable = 1'b1;
  logic [11:0] snap;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    grant_t g;
    rsp_t   r;
    cyc++;
    if (!reset) begin
      run = 0;
      prev_en = 1'b0;
    end else begin
      if (req_ready != '0) begin
        chk("ready_onehot", int'($onehot(req_ready)), 1);
        if (exp_grant.size() == 0) chk("ready_unexpected", int'(req_ready), 0);
        else begin
          g = exp_grant.pop_front();
          chk("grant_idx", int'(req_ready), 1 << g.idx);
          if (g.gap != 0) chk("grant_spacing", cyc - last_ready, g.gap);
        end
        last_ready = cyc;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) ready_cyc[i] = cyc;
      end
      if (rsp_valid != '0) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", int'(rsp_valid), 0);
        else begin
          r = exp_rsp.pop_front();
          chk("rsp_idx", int'(rsp_valid), 1 << r.idx);
          chk("rsp_data", int'(rsp_data), int'(r.data));
          chk("rsp_err", int'(rsp_err), int'(r.err));
          chk("rsp_latency", cyc - ready_cyc[r.idx], r.lat);
        end
      end else if (rsp_err) chk("rsp_err_idle", int'(rsp_err), 0);
      if (spi_enable && !prev_en) begin
        en_rises++;
        run = 1;
        stable = 1'b1;
        snap = {spi_slaveno, spi_cpol, spi_cpha, spi_data_out};
      end else if (spi_enable) begin
        run++;
        if ({spi_slaveno, spi_cpol, spi_cpha, spi_data_out} != snap) stable = 1'b0;
      end else if (prev_en) begin
        chk("enable_len", run, 20);
        chk("xfer_stable", int'(stable), 1);
      end
      prev_en = spi_enable;
    end
  end

  task automatic push_txn(input int idx, input int gap, input logic [7:0] data,
                          input logic err, input int lat);
    grant_t g;
    rsp_t   r;
    g.idx = idx; g.gap = gap;
    r.idx = idx; r.data = data; r.err = err; r.lat = lat;
    exp_grant.push_back(g);
    exp_rsp.push_back(r);
  endtask

  task automatic wait_readies(input int n, input int maxc);
    int seen = 0;
    int c = 0;
    while (seen < n && c < maxc) begin
      @(negedge clk);
      c++;
      if (req_ready != '0) seen++;
    end
    if (seen < n) chk("ready_timeout", seen, n);
  endtask

  task automatic wait_done(input int maxc);
    int c = 0;
    while ((busy || exp_rsp.size() != 0 || exp_grant.size() != 0) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk("done_timeout", int'(c < maxc), 1);
  endtask

  initial begin
    grant_t g;
    int n, c;
    // Reset: every output cleared.
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({req_ready, rsp_valid, rsp_err, busy, spi_enable, spi_cpol,
                               spi_cpha, spi_slaveno, rsp_data, spi_data_out}), 0);
    reset = 1'b1;

    // Single request, then disturb its inputs mid-transfer.
    req_slave = 6'b00_00_01; req_mode = 6'b00_00_10; req_data = 24'h0000A5;
    push_txn(0, 0, 8'h3C, 1'b0, 23);
    req_valid = 3'b001;
    wait_readies(1, 20);
    req_valid = '0;
    chk("setup_slaveno", int'(spi_slaveno), 1);
    chk("setup_mode", int'({spi_cpol, spi_cpha}), 2);
    chk("setup_data", int'(spi_data_out), 8'hA5);
    chk("setup_enable", int'(spi_enable), 0);
    chk("setup_busy", int'(busy), 1);
    c = 0;
    while (!spi_enable && c < 20) begin @(negedge clk); c++; end
    chk("enable_seen", int'(spi_enable), 1);
    repeat (3) @(negedge clk);
    req_data[7:0] = 8'hFF;
    req_mode[1:0] = 2'b01;
    wait_done(100);

    // Requester 2 alone moves the pointer back to 0.
    req_slave = {2'd2, 2'd1, 2'd0}; req_mode = {2'b11, 2'b01, 2'b00};
    req_data = {8'h44, 8'h22, 8'h11};
    push_txn(2, 0, 8'hDD, 1'b0, 23);
    req_valid = 3'b100;
    wait_readies(1, 20);
    req_valid = '0;
    wait_done(100);

    // Round robin with all three held.
    for (int k = 0; k < 6; k++)
      push_txn(k % 3, (k == 0) ? 0 : 26, (k % 3 == 0) ? 8'h88 : (k % 3 == 1) ? 8'hBB : 8'hDD,
               1'b0, 23);
    req_valid = 3'b111;
    wait_readies(6, 400);
    req_valid = '0;
    wait_done(100);

    // Pointer wrap after requester 2: 011 -> 0 then 1.
    req_slave = {2'd0, 2'd0, 2'd2}; req_mode = {2'b00, 2'b01, 2'b01};
    req_data = {8'h00, 8'h0F, 8'h5A};
    push_txn(0, 0, 8'hC3, 1'b0, 23);
    push_txn(1, 26, 8'h96, 1'b0, 23);
    req_valid = 3'b011;
    wait_readies(2, 100);
    req_valid = '0;
    wait_done(100);

    // Reset during the 10th enable cycle; pointer must restart at 0.
    g.idx = 0; g.gap = 0;
    exp_grant.push_back(g);
    req_valid = 3'b011;
    wait_readies(1, 20);
    n = 0; c = 0;
    while (n < 10 && c < 100) begin
      @(negedge clk);
      c++;
      if (spi_enable) n++;
    end
    chk("enable_before_reset", n, 10);
    push_txn(0, 0, 8'hC3, 1'b0, 23);
    push_txn(1, 26, 8'h96, 1'b0, 23);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_enable", int'(spi_enable), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rsp", int'(rsp_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    wait_readies(2, 200);
    req_valid = '0;
    wait_done(100);

    // Invalid slave on requester 1: error response, spi_* untouched.
    req_slave = {2'd0, 2'd3, 2'd0}; req_mode = {2'b00, 2'b10, 2'b00};
    req_data = {8'h00, 8'hEE, 8'h00};
    push_txn(1, 0, 8'h00, 1'b1, 1);
    req_valid = 3'b010;
    wait_readies(1, 20);
    req_valid = '0;
    chk("err_slaveno_held", int'(spi_slaveno), 0);
    chk("err_mode_held", int'({spi_cpol, spi_cpha}), 1);
    chk("err_data_held", int'(spi_data_out), 8'h0F);
    chk("err_enable", int'(spi_enable), 0);
    wait_done(50);
    repeat (3) @(negedge clk);

    chk("enable_count", en_rises, 13);
    chk("grants_left", exp_grant.size(), 0);
    chk("rsps_left", exp_rsp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Round-robin transaction scheduler in front of the SPI master, sharing it among NREQ requesters.
- Accepts one byte transaction at a time: target slave number, SPI mode and transmit byte.
- Drives the master's slave select, cpol/cpha, data input and enable, times the transfer, captures the received byte and returns it to the requester that issued it.
- Sits between system-side requesters and the SPI top level's master control inputs.

Parameters:
- NREQ, 3, number of requesters (2..8).
- SETUP_CYCLES, 2, cycles slaveno/cpol/cpha/data are held stable with enable low before the transfer (1..15).
- XFER_CYCLES, 20, cycles enable is held high per byte transfer (8..255).
- IDLE_GAP, 1, enable-low cycles forced between consecutive transactions (0..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester transaction request; held until req_ready.
- req_slave  in  2*NREQ  per-requester target slave number, bits [2i+1:2i].
- req_mode  in  2*NREQ  per-requester {cpol,cpha}, bits [2i+1:2i].
- req_data  in  8*NREQ  per-requester transmit byte, bits [8i+7:8i].
- req_ready  out  NREQ  one-cycle accept pulse, one-hot.
- rsp_valid  out  NREQ  one-cycle response pulse, one-hot, to the granted requester.
- rsp_data  out  8  received byte, valid with rsp_valid.
- rsp_err  out  1  high with rsp_valid when the request was rejected.
- busy  out  1  high whenever state is not IDLE.
- spi_slaveno  out  2  to master slaveno.
- spi_cpol  out  1  to master cpol.
- spi_cpha  out  1  to master cpha.
- spi_enable  out  1  to master enable.
- spi_data_out  out  8  to master data input.
- spi_data_in  in  8  from master data output.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - req_ready, rsp_valid, rsp_err, busy, spi_enable, spi_cpol and spi_cpha are 0.
  - spi_slaveno is 0; rsp_data and spi_data_out are 0x00.
  - Round-robin pointer is set so requester 0 has highest priority.
  - Gap counter is 0.
- Reset mid-transaction aborts immediately: spi_enable drops at that edge and no rsp_valid is issued. The requester must re-request.
- States: IDLE, SETUP, XFER, CAPTURE, RESP, GAP.
- IDLE:
  - If any req_valid is high and the gap counter is 0, grant g.
  - g is the first set req_valid at or after the pointer, searching upward and wrapping at NREQ-1 -> 0.
  - At that edge:
    - Latch req_slave[g], req_mode[g] and req_data[g].
    - Assert req_ready[g] for exactly one cycle.
    - Set the pointer to (g+1) mod NREQ.
  - Next state: SETUP if req_slave[g] is 0..2; RESP with error if req_slave[g]==3.
- SETUP:
  - Drive spi_slaveno, spi_cpol, spi_cpha and spi_data_out from the latched values; spi_enable=0.
  - Lasts exactly SETUP_CYCLES cycles, then XFER.
- XFER:
  - spi_enable=1 for exactly XFER_CYCLES cycles.
  - slaveno, mode and data must not change while in this state.
- CAPTURE:
  - One cycle with spi_enable=0.
  - Register spi_data_in into rsp_data at the end of this cycle.
- RESP:
  - One cycle: rsp_valid[g]=1.
  - Normal path: rsp_err=0 and rsp_data holds the captured byte.
  - Error path: rsp_err=1 and rsp_data=0x00.
  - Then go to GAP, loading the counter with IDLE_GAP. If IDLE_GAP==0, go directly to IDLE.
- GAP: spi_enable=0; decrement the counter each cycle; enter IDLE when it reaches 0.
- Latency, valid path: req_ready high in the cycle after the grant edge, which is the first SETUP cycle. rsp_valid is high SETUP_CYCLES+XFER_CYCLES+1 cycles after req_ready's first cycle.
- Latency, error path: rsp_valid is high the cycle after req_ready. The spi_* outputs keep their previous values and spi_enable stays 0.
- Requests arriving while busy are held pending; they are never dropped and never granted until IDLE.
- Changes to req_* inputs after acceptance have no effect on the transaction in flight.
- Simultaneous requests are resolved strictly by the pointer. A requester is never granted twice in a row while another requester's valid is continuously asserted.
- spi_cpol/spi_cpha hold their last values between transactions, so the bus idle level does not glitch.

Test Plan:
- Reset and single request (NREQ=3, SETUP=2, XFER=20, GAP=1): reset low 3 cycles -> all outputs 0. Then req_valid=001, slave=1, mode=2'b10, data=0xA5 -> req_ready=001 for one cycle; spi_slaveno=1, spi_cpol=1, spi_cpha=0; spi_enable high exactly 20 cycles. Slave returns 0x3C -> rsp_valid=001 at 23 cycles after req_ready, rsp_data=0x3C, rsp_err=0.
- Round-robin: req_valid=111 held continuously -> grant order 0,1,2,0,1,2; each req_ready is one-hot; successive transactions are separated by 1 enable-low GAP cycle.
- Pointer wrap: after granting requester 2, requests on 011 -> requester 0 granted first, then 1.
- Invalid slave: requester 1 sends slave=3 -> req_ready=010, then next cycle rsp_valid=010, rsp_err=1, rsp_data=0x00; spi_enable never asserted.
- Reset mid-XFER: reset low at the 10th enable cycle -> spi_enable 0 at that edge, no rsp_valid, busy=0. After reset release, the still-asserted req_valid is granted to requester 0 first.
- Input stability: change req_data and req_mode of the granted requester during XFER -> spi_data_out, spi_cpol and spi_cpha unchanged until RESP.
